// File: rtl/btb.sv
// Branch target buffer: direct-mapped table of 2^IDX_BITS entries, each with
// valid, tag, target and a 2-bit saturating direction counter.
//
// Ports:
//   clk            - clock; all table updates on the rising edge
//   rst            - asynchronous active-low reset; clears the whole table
//   fetch_pc       - fetch-stage PC, looked up combinationally
//   ex_pc          - execute-stage PC, selects the entry to update
//   ex_opcode      - execute-stage opcode; only branch opcodes update
//   target_entry   - resolved branch target from execute
//   gflag/lflag/zflag - condition flags used to resolve the branch
//   btb_target     - predicted target for fetch_pc (0 on miss)
//   btb_prediction - fetch_pc predicted taken
module btb #(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fetch_pc,
  input  logic [15:0] ex_pc,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] target_entry,
  input  logic        gflag,
  input  logic        lflag,
  input  logic        zflag,
  output logic [15:0] btb_target,
  output logic        btb_prediction
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = 16 - IDX_BITS;

  typedef enum logic [3:0] {
    OP_BRZ = 4'b1001,
    OP_BRG = 4'b1010,
    OP_BRL = 4'b1011,
    OP_BRA = 4'b1100
  } br_op_e;

  logic [ENTRIES-1:0]            r_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] r_tag;
  logic [ENTRIES-1:0][15:0]      r_target;
  logic [ENTRIES-1:0][1:0]       r_ctr;

  logic [IDX_BITS-1:0] w_fidx;
  logic [IDX_BITS-1:0] w_eidx;
  logic [TAG_W-1:0]    w_ftag;
  logic [TAG_W-1:0]    w_etag;
  logic                w_fhit;
  logic                w_ehit;
  logic                w_is_branch;
  logic                w_taken;
  logic [1:0]          w_ectr;

  assign w_fidx = fetch_pc[IDX_BITS-1:0];
  assign w_eidx = ex_pc[IDX_BITS-1:0];
  assign w_ftag = fetch_pc[15:IDX_BITS];
  assign w_etag = ex_pc[15:IDX_BITS];

  // Lookup reads registered state only, so a same-cycle update to the same
  // entry is seen by fetch one cycle later.
  assign w_fhit         = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign btb_prediction = w_fhit && r_ctr[w_fidx][1];
  assign btb_target     = w_fhit ? r_target[w_fidx] : '0;

  assign w_ehit = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);
  assign w_ectr = r_ctr[w_eidx];

  always_comb begin
    w_is_branch = 1'b0;
    w_taken     = 1'b0;
    case (ex_opcode)
      OP_BRZ: begin w_is_branch = 1'b1; w_taken = zflag; end
      OP_BRG: begin w_is_branch = 1'b1; w_taken = gflag; end
      OP_BRL: begin w_is_branch = 1'b1; w_taken = lflag; end
      OP_BRA: begin w_is_branch = 1'b1; w_taken = 1'b1;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_ctr    <= {ENTRIES{2'b01}};
    end else if (w_is_branch) begin
      if (w_ehit) begin
        if (w_taken) begin
          if (w_ectr != 2'b11) r_ctr[w_eidx] <= w_ectr + 2'd1;
          r_target[w_eidx] <= target_entry;
        end else if (w_ectr != 2'b00) begin
          r_ctr[w_eidx] <= w_ectr - 2'd1;
        end
      end else if (w_taken) begin
        // Taken miss allocates, evicting whatever tag held this index.
        r_valid[w_eidx]  <= 1'b1;
        r_tag[w_eidx]    <= w_etag;
        r_target[w_eidx] <= target_entry;
        r_ctr[w_eidx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_btb.sv
module tb_btb;

  logic        clk;
  logic        rst;
  logic [15:0] fetch_pc;
  logic [15:0] ex_pc;
  logic [3:0]  ex_opcode;
  logic [15:0] target_entry;
  logic        gflag;
  logic        lflag;
  logic        zflag;
  logic [15:0] btb_target;
  logic        btb_prediction;

  int errors;
  int checks;

  btb #(.IDX_BITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .ex_pc          (ex_pc),
    .ex_opcode      (ex_opcode),
    .target_entry   (target_entry),
    .gflag          (gflag),
    .lflag          (lflag),
    .zflag          (zflag),
    .btb_target     (btb_target),
    .btb_prediction (btb_prediction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [15:0] pc, input logic [3:0] op, input logic [15:0] tgt,
                        input logic z, input logic g, input logic l);
    ex_pc = pc; ex_opcode = op; target_entry = tgt; zflag = z; gflag = g; lflag = l;
  endtask

  task automatic idle();
    set_ex(16'h0, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch_pc = 16'd2;
    idle();
    #1;
    checks++;
    if (btb_prediction !== 1'b0) begin errors++; $display("FAIL reset_pred got=%b exp=0", btb_prediction); end
    checks++;
    if (btb_target !== 16'h0) begin errors++; $display("FAIL reset_target got=%h exp=0000", btb_target); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_sweep();
    for (int i = 0; i <= 20; i++) begin
      fetch_pc = 16'(i);
      set_ex(16'(i), 4'b0000, 16'h1234, 1'b1, 1'b1, 1'b1);
      tick();
      checks++;
      if (btb_prediction !== 1'b0 || btb_target !== 16'h0) begin
        errors++; $display("FAIL sweep pc=%0d got pred=%b tgt=%h exp pred=0 tgt=0000", i, btb_prediction, btb_target);
      end
    end
    idle();
  endtask

  task automatic test_alloc();
    set_ex(16'd2, 4'b1001, 16'd2, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    fetch_pc = 16'd2; #1;
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'd2) begin
      errors++; $display("FAIL alloc_hit got pred=%b tgt=%h exp pred=1 tgt=0002", btb_prediction, btb_target);
    end
    fetch_pc = 16'd18; #1;
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'h0) begin
      errors++; $display("FAIL alias_miss got pred=%b tgt=%h exp pred=0 tgt=0000", btb_prediction, btb_target);
    end
  endtask

  task automatic test_not_taken();
    fetch_pc = 16'd2;
    set_ex(16'd2, 4'b1001, 16'd2, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'd2) begin
      errors++; $display("FAIL nt1 got pred=%b tgt=%h exp pred=0 tgt=0002", btb_prediction, btb_target);
    end
    tick();
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'd2) begin
      errors++; $display("FAIL nt2 got pred=%b tgt=%h exp pred=0 tgt=0002", btb_prediction, btb_target);
    end
    // counter 00 -> 01: still not taken, but hit-taken overwrites target
    set_ex(16'd2, 4'b1001, 16'h0022, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'h0022) begin
      errors++; $display("FAIL t_from_sn got pred=%b tgt=%h exp pred=0 tgt=0022", btb_prediction, btb_target);
    end
    tick();
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'h0022) begin
      errors++; $display("FAIL t_to_wt got pred=%b tgt=%h exp pred=1 tgt=0022", btb_prediction, btb_target);
    end
    // different tag on same index replaces the entry
    set_ex(16'd18, 4'b1100, 16'h0077, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    fetch_pc = 16'd18; #1;
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'h0077) begin
      errors++; $display("FAIL replace_new got pred=%b tgt=%h exp pred=1 tgt=0077", btb_prediction, btb_target);
    end
    fetch_pc = 16'd2; #1;
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'h0) begin
      errors++; $display("FAIL replace_old got pred=%b tgt=%h exp pred=0 tgt=0000", btb_prediction, btb_target);
    end
  endtask

  task automatic test_saturate();
    fetch_pc = 16'd5;
    set_ex(16'd5, 4'b1100, 16'h0040, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (btb_prediction !== 1'b1 || btb_target !== 16'h0040) begin
        errors++; $display("FAIL sat_taken%0d got pred=%b tgt=%h exp pred=1 tgt=0040", i, btb_prediction, btb_target);
      end
    end
    // from 11 one not-taken leaves 10, still predicted taken
    set_ex(16'd5, 4'b1001, 16'h0099, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'h0040) begin
      errors++; $display("FAIL sat_nt got pred=%b tgt=%h exp pred=1 tgt=0040", btb_prediction, btb_target);
    end
  endtask

  task automatic test_opcodes();
    set_ex(16'd9, 4'b1010, 16'h0090, 1'b0, 1'b1, 1'b0);
    tick();
    set_ex(16'd10, 4'b1011, 16'h00A0, 1'b0, 1'b0, 1'b1);
    tick();
    set_ex(16'd11, 4'b1010, 16'h00B0, 1'b1, 1'b0, 1'b1);
    tick();
    set_ex(16'd12, 4'b1101, 16'h00C0, 1'b1, 1'b1, 1'b1);
    tick();
    set_ex(16'd13, 4'b1000, 16'h00D0, 1'b1, 1'b1, 1'b1);
    tick();
    set_ex(16'd14, 4'b1011, 16'h00E0, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    fetch_pc = 16'd9; #1;
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'h0090) begin
      errors++; $display("FAIL op_brg got pred=%b tgt=%h exp pred=1 tgt=0090", btb_prediction, btb_target);
    end
    fetch_pc = 16'd10; #1;
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'h00A0) begin
      errors++; $display("FAIL op_brl got pred=%b tgt=%h exp pred=1 tgt=00a0", btb_prediction, btb_target);
    end
    for (int p = 11; p <= 14; p++) begin
      fetch_pc = 16'(p); #1;
      checks++;
      if (btb_prediction !== 1'b0 || btb_target !== 16'h0) begin
        errors++; $display("FAIL op_none pc=%0d got pred=%b tgt=%h exp pred=0 tgt=0000", p, btb_prediction, btb_target);
      end
    end
  endtask

  task automatic test_same_cycle();
    fetch_pc = 16'd7;
    set_ex(16'd7, 4'b1100, 16'h0010, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'h0) begin
      errors++; $display("FAIL same_pre got pred=%b tgt=%h exp pred=0 tgt=0000", btb_prediction, btb_target);
    end
    tick();
    idle();
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'h0010) begin
      errors++; $display("FAIL same_post got pred=%b tgt=%h exp pred=1 tgt=0010", btb_prediction, btb_target);
    end
  endtask

  task automatic test_async_reset();
    fetch_pc = 16'd5;
    @(posedge clk);
    #3;
    checks++;
    if (btb_prediction !== 1'b1) begin errors++; $display("FAIL pre_rst got pred=%b exp=1", btb_prediction); end
    rst = 1'b0;
    #1;
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'h0) begin
      errors++; $display("FAIL async_rst got pred=%b tgt=%h exp pred=0 tgt=0000", btb_prediction, btb_target);
    end
    set_ex(16'd5, 4'b1100, 16'h0040, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'h0) begin
      errors++; $display("FAIL rst_upd got pred=%b tgt=%h exp pred=0 tgt=0000", btb_prediction, btb_target);
    end
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int p = 0; p < 20; p++) begin
      fetch_pc = 16'(p); #1;
      checks++;
      if (btb_prediction !== 1'b0 || btb_target !== 16'h0) begin
        errors++; $display("FAIL post_rst pc=%0d got pred=%b tgt=%h exp pred=0 tgt=0000", p, btb_prediction, btb_target);
      end
    end
    fetch_pc = 16'd3;
    set_ex(16'd3, 4'b1100, 16'h0033, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'h0033) begin
      errors++; $display("FAIL resume got pred=%b tgt=%h exp pred=1 tgt=0033", btb_prediction, btb_target);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sweep();
    test_alloc();
    test_not_taken();
    test_saturate();
    test_opcodes();
    test_same_cycle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
